// File: rtl/sha3_pkg.sv
// Shared SHA-3 digest definitions: TID encoding, digest lengths and beat arithmetic.
package sha3_pkg;

  typedef enum logic [1:0] {
    TID_SHA3_224 = 2'd0,
    TID_SHA3_256 = 2'd1,
    TID_SHA3_384 = 2'd2,
    TID_SHA3_512 = 2'd3
  } tid_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int LEN_224   = 224;
  localparam int LEN_256   = 256;
  localparam int LEN_384   = 384;
  localparam int LEN_512   = 512;
  localparam int HOLD_BITS = 512;

  function automatic int beats(input int len, input int width);
    return (len + width - 1) / width;
  endfunction

  function automatic int digest_len(input logic [1:0] tid);
    case (tid_e'(tid))
      TID_SHA3_224: return LEN_224;
      TID_SHA3_256: return LEN_256;
      TID_SHA3_384: return LEN_384;
      default:      return LEN_512;
    endcase
  endfunction

endpackage

// File: rtl/sha3_digest_tx.sv
// Streams the leading 224..512 bits of a final Keccak state out as AXI-Stream beats,
// little-endian, with a partial-byte keep mask on a short final beat.
module sha3_digest_tx
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [4:0][4:0][63:0]     Din,
  input  logic                      Din_valid,
  input  logic [1:0]                TID,
  output logic [DATA_WIDTH-1:0]     m_TDATA,
  output logic [DATA_WIDTH/8-1:0]   m_TKEEP,
  output logic                      m_TVALID,
  input  logic                      m_TREADY,
  output logic                      m_TLAST,
  output logic [1:0]                m_TID,
  output logic                      Busy,
  output logic                      Overrun
);

  localparam int KEEP_W    = DATA_WIDTH / 8;
  localparam int MAX_BEATS = HOLD_BITS / DATA_WIDTH;
  localparam int CNT_W     = $clog2(MAX_BEATS);

  state_e                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [1:0]             tid_reg, tid_next;
  logic                   overrun_reg, overrun_next;
  logic                   capture;
  logic [HOLD_BITS-1:0]   hold_reg;
  logic [HOLD_BITS-1:0]   din_lanes;
  logic [DATA_WIDTH-1:0]  beat_arr [MAX_BEATS];
  logic [DATA_WIDTH-1:0]  beat_raw;
  logic [KEEP_W-1:0]      keep;
  logic                   last_beat;
  int                     digest_bits;
  int                     rem_bytes;
  logic                   unused_lanes;

  // Only lanes 0..7 can contribute to a digest of at most 512 bits.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign din_lanes[gi*64 +: 64] = Din[gi/5][gi%5];
  end
  assign unused_lanes = ^{Din[4], Din[3], Din[2], Din[1][4:3]};

  for (genvar gi = 0; gi < MAX_BEATS; gi++) begin : g_beat
    assign beat_arr[gi] = hold_reg[gi*DATA_WIDTH +: DATA_WIDTH];
  end
  assign beat_raw = beat_arr[cnt_reg];

  assign digest_bits = digest_len(tid_reg);
  assign rem_bytes   = (digest_bits % DATA_WIDTH) / 8;
  assign last_beat   = (int'(cnt_reg) == beats(digest_bits, DATA_WIDTH) - 1);

  always_comb begin
    keep = '1;
    if (last_beat && rem_bytes != 0) begin
      for (int b = 0; b < KEEP_W; b++) keep[b] = (b < rem_bytes);
    end
  end

  // Outputs come only from registered state, never straight from m_TREADY.
  always_comb begin
    m_TDATA = '0;
    if (state_reg == SEND) begin
      for (int b = 0; b < KEEP_W; b++) m_TDATA[b*8 +: 8] = keep[b] ? beat_raw[b*8 +: 8] : 8'h00;
    end
  end

  assign m_TKEEP  = (state_reg == SEND) ? keep : '0;
  assign m_TVALID = (state_reg == SEND);
  assign m_TLAST  = (state_reg == SEND) && last_beat;
  assign m_TID    = tid_reg;
  assign Busy     = (state_reg == SEND);
  assign Overrun  = overrun_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tid_next     = tid_reg;
    overrun_next = 1'b0;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Din_valid) begin
          capture    = 1'b1;
          tid_next   = TID;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (m_TREADY) begin
          if (last_beat) begin
            cnt_next = '0;
            if (Din_valid) begin
              capture  = 1'b1;
              tid_next = TID;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        if (Din_valid && !(m_TREADY && last_beat)) overrun_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      tid_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      tid_reg     <= tid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_ff @(posedge ACLK) begin
    if (capture) hold_reg <= din_lanes;
  end

endmodule

// File: tb/tb_sha3_digest_tx.sv
// Bench for sha3_digest_tx: a 16-bit instance checked every cycle against a beat-queue
// model, and a 64-bit instance checked with literal beats for the partial-keep case.
`timescale 1ns/1ps
module tb_sha3_digest_tx;

  localparam int W = 16;

  logic ACLK = 1'b0;
  logic ARESET;
  logic [4:0][4:0][63:0] din;

  logic          din_valid;
  logic [1:0]    tid;
  logic          ready;
  logic [W-1:0]  tdata;
  logic [1:0]    tkeep;
  logic          tvalid, tlast, busy, overrun;
  logic [1:0]    tid_out;

  logic          valid64, ready64;
  logic [1:0]    tid64;
  logic [63:0]   tdata64;
  logic [7:0]    tkeep64;
  logic          tvalid64, tlast64, busy64, overrun64;
  logic [1:0]    tid_out64;

  always #5 ACLK = ~ACLK;

  sha3_digest_tx #(.DATA_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .Din(din), .Din_valid(din_valid), .TID(tid),
    .m_TDATA(tdata), .m_TKEEP(tkeep), .m_TVALID(tvalid), .m_TREADY(ready),
    .m_TLAST(tlast), .m_TID(tid_out), .Busy(busy), .Overrun(overrun)
  );

  sha3_digest_tx #(.DATA_WIDTH(64)) dut64 (
    .ACLK(ACLK), .ARESET(ARESET), .Din(din), .Din_valid(valid64), .TID(tid64),
    .m_TDATA(tdata64), .m_TKEEP(tkeep64), .m_TVALID(tvalid64), .m_TREADY(ready64),
    .m_TLAST(tlast64), .m_TID(tid_out64), .Busy(busy64), .Overrun(overrun64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- model: queue of beats still owed for the digest in flight
  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [1:0]   id;
  } beat_t;

  beat_t        exp_q[$];
  logic         exp_ovr = 1'b0;
  int           ovr_seen = 0;
  int           beat_no = 0;
  logic [W-1:0] log_data[$];
  logic         log_last[$];
  logic         was_busy, fin;

  function automatic int len_of(input logic [1:0] t);
    case (t)
      2'd0:    return 224;
      2'd1:    return 256;
      2'd2:    return 384;
      default: return 512;
    endcase
  endfunction

  task automatic load_digest(input logic [4:0][4:0][63:0] d, input logic [1:0] t);
    logic [511:0] cap;
    for (int k = 0; k < 8; k++) cap[k*64 +: 64] = d[k/5][k%5];
    for (int n = 0; n < len_of(t) / W; n++) begin
      beat_t b;
      b.data = cap[n*W +: W];
      b.last = (n == len_of(t) / W - 1);
      b.id   = t;
      exp_q.push_back(b);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESET) begin
      chk("rst_tvalid", tvalid, 1'b0);
      chk("rst_tlast", tlast, 1'b0);
      chk("rst_tdata", tdata, 16'h0);
      chk("rst_tkeep", tkeep, 2'b00);
      chk("rst_tid", tid_out, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      chk("overrun", overrun, exp_ovr);
      if (overrun) ovr_seen++;
      chk("tvalid", tvalid, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("tdata", tdata, exp_q[0].data);
        chk("tlast", tlast, exp_q[0].last);
        chk("tkeep", tkeep, 2'b11);
        chk("tid", tid_out, exp_q[0].id);
      end else begin
        chk("tlast_idle", tlast, 1'b0);
      end
      // predict the coming rising edge from the inputs now on the wires
      exp_ovr  = 1'b0;
      fin      = 1'b0;
      was_busy = (exp_q.size() != 0);
      if (was_busy && ready) begin
        $display("beat %0d data=%h last=%0d tid=%0d", beat_no, tdata, tlast, tid_out);
        log_data.push_back(tdata);
        log_last.push_back(tlast);
        beat_no++;
        fin = (exp_q.size() == 1);
        void'(exp_q.pop_front());
      end
      if (din_valid) begin
        if (!was_busy || fin) begin
          load_digest(din, tid);
          beat_no = 0;
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic fill(input logic [7:0] seed);
    for (int k = 0; k < 25; k++) din[k/5][k%5] = {seed, 24'(k), 32'hA5A5_0000 + 32'(k)};
  endtask

  task automatic send(input logic [1:0] t);
    din_valid = 1'b1;
    tid = t;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 300) begin
      tick();
      n++;
    end
    chk(name, n < 300, 1'b1);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
  endtask

  logic [63:0] e64 [4];
  int nlast;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; din_valid = 1'b0; tid = 2'd0; ready = 1'b1;
    valid64 = 1'b0; tid64 = 2'd0; ready64 = 1'b1;
    din = '0;
    tick(); tick(); tick();
    chk("rst64_tvalid", tvalid64, 1'b0);
    chk("rst64_tdata", tdata64, 64'h0);
    chk("rst64_tkeep", tkeep64, 8'h00);
    ARESET = 1'b0;
    tick();

    // SHA3-256 at 16 bits: 16 beats, little-endian lane 0 first
    fill(8'h10);
    din[0][0] = 64'h66D71EBFF8C6FFA7;
    clear_log();
    send(2'd1);
    wait_idle("t1_done");
    chk("t1_beats", log_data.size(), 16);
    if (log_data.size() >= 16) begin
      chk("t1_beat0", log_data[0], 16'hFFA7);
      chk("t1_beat3", log_data[3], 16'h66D7);
      nlast = 0;
      foreach (log_last[i]) if (log_last[i]) nlast++;
      chk("t1_last_count", nlast, 1);
      chk("t1_last_pos", log_last[15], 1'b1);
    end

    // SHA3-224 at 64 bits: 4 beats, last beat half-kept with zeroed upper bytes
    fill(8'h20);
    din[0][0] = 64'h0123456789ABCDEF;
    din[0][1] = 64'hFEDCBA9876543210;
    din[0][2] = 64'h0F1E2D3C4B5A6978;
    din[0][3] = 64'hDEADBEEFCAFEF00D;
    e64[0] = 64'h0123456789ABCDEF;
    e64[1] = 64'hFEDCBA9876543210;
    e64[2] = 64'h0F1E2D3C4B5A6978;
    e64[3] = 64'h00000000CAFEF00D;
    valid64 = 1'b1; tid64 = 2'd0;
    tick();
    valid64 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      $display("w64 beat %0d data=%h keep=%h last=%0d", n, tdata64, tkeep64, tlast64);
      chk("w64_tvalid", tvalid64, 1'b1);
      chk("w64_tdata", tdata64, e64[n]);
      chk("w64_tkeep", tkeep64, (n == 3) ? 8'h0F : 8'hFF);
      chk("w64_tlast", tlast64, n == 3);
      chk("w64_tid", tid_out64, 2'd0);
      tick();
    end
    chk("w64_idle_tvalid", tvalid64, 1'b0);
    chk("w64_idle_busy", busy64, 1'b0);

    // SHA3-512 with ready toggling every cycle
    fill(8'h30);
    din[1][2] = 64'hBEEF_0000_0000_1234;
    clear_log();
    send(2'd3);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        ready = (n % 2 == 0);
        tick();
        n++;
      end
      chk("t3_timeout", n < 300, 1'b1);
    end
    ready = 1'b1;
    wait_idle("t3_done");
    chk("t3_beats", log_data.size(), 32);
    if (log_data.size() >= 32) begin
      chk("t3_beat28", log_data[28], 16'h1234);
      chk("t3_beat31", log_data[31], 16'hBEEF);
    end

    // second Din_valid mid-digest is dropped with an Overrun pulse
    fill(8'h40);
    clear_log();
    ovr_seen = 0;
    send(2'd3);
    repeat (5) tick();
    fill(8'h41);
    din_valid = 1'b1; tid = 2'd0;
    tick();
    din_valid = 1'b0;
    wait_idle("t4_done");
    chk("t4_overrun_pulses", ovr_seen, 1);
    chk("t4_beats", log_data.size(), 32);
    if (log_data.size() >= 32) begin
      chk("t4_beat3", log_data[3], 16'h4000);
      chk("t4_beat4", log_data[4], 16'h0001);
    end

    // back-to-back: new Din_valid on the final handshake
    fill(8'h50);
    clear_log();
    send(2'd0);
    begin
      int n = 0;
      while (!(tlast && ready) && n < 100) begin
        tick();
        n++;
      end
      chk("t5_found_last", n < 100, 1'b1);
    end
    fill(8'h51);
    din[0][0] = 64'h0000_0000_0000_5A5A;
    din_valid = 1'b1; tid = 2'd1;
    tick();
    din_valid = 1'b0;
    chk("t5_tvalid", tvalid, 1'b1);
    chk("t5_beat0", tdata, 16'h5A5A);
    chk("t5_tid", tid_out, 2'd1);
    wait_idle("t5_done");
    chk("t5_beats", log_data.size(), 30);

    // reset at beat 7 of SHA3-384, then a fresh digest
    fill(8'h60);
    clear_log();
    send(2'd2);
    begin
      int n = 0;
      while (log_data.size() < 7 && n < 100) begin
        tick();
        n++;
      end
      chk("t6_reach_beat7", n < 100, 1'b1);
    end
    #2;
    ARESET = 1'b1;
    #1;
    chk("t6_tvalid", tvalid, 1'b0);
    chk("t6_tlast", tlast, 1'b0);
    chk("t6_tdata", tdata, 16'h0);
    chk("t6_tkeep", tkeep, 2'b00);
    chk("t6_tid", tid_out, 2'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_overrun", overrun, 1'b0);
    tick(); tick();
    ARESET = 1'b0;
    tick();
    fill(8'h61);
    din[0][0] = 64'h0000_0000_0000_ABCD;
    clear_log();
    send(2'd1);
    chk("t6_new_tvalid", tvalid, 1'b1);
    chk("t6_new_beat0", tdata, 16'hABCD);
    wait_idle("t6_done");
    chk("t6_new_beats", log_data.size(), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_digest_tx.md
SHA3_DIGEST_TX -- requirements
Module: sha3_digest_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, output beat width in bits; legal values 16, 32, 64.
REQ-002 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port ARESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Din  input  [4:0][4:0][63:0]  final Keccak state from the keccak_xor stage; lane k = Din[k/5][k%5].
REQ-005 SHALL have port Din_valid  input  1  one-cycle pulse (keccak Ready) qualifying Din.
REQ-006 SHALL have port TID  input  2  digest select, sampled with Din_valid: 0=SHA3-224, 1=-256, 2=-384, 3=-512.
REQ-007 SHALL have port m_TDATA  output  DATA_WIDTH  digest beat.
REQ-008 SHALL have port m_TKEEP  output  DATA_WIDTH/8  byte-valid mask.
REQ-009 SHALL have port m_TVALID  output  1  AXI-Stream valid.
REQ-010 SHALL have port m_TREADY  input  1  AXI-Stream ready from sink.
REQ-011 SHALL have port m_TLAST  output  1  final beat of digest.
REQ-012 SHALL have port m_TID  output  2  latched TID of digest in flight.
REQ-013 SHALL have port Busy  output  1  high while a digest is held or being sent.
REQ-014 SHALL have port Overrun  output  1  one-cycle pulse when a Din_valid is dropped.

Function
REQ-015 SHALL implement FSM states IDLE and SEND.
REQ-016 IDLE + Din_valid SHALL capture lanes 0..7 (512 bits) and TID into a holding register, clear beat counter, enter SEND.
REQ-017 m_TVALID SHALL rise the cycle after the capturing Din_valid (latency 1) and stay high in SEND.
REQ-018 Digest length L SHALL be 224/256/384/512 bits per latched TID; beat count N = ceil(L/DATA_WIDTH).
REQ-019 Beat n SHALL carry captured bits [n*DATA_WIDTH +: DATA_WIDTH], lane 0 bit 0 first (SHA-3 little-endian byte order, byte 0 in m_TDATA[7:0]).
REQ-020 m_TKEEP SHALL be all ones except on a partial final beat, where only the low (L mod DATA_WIDTH)/8 bytes are set (SHA3-224, DATA_WIDTH=64: 8'h0F); masked bytes SHALL read zero.
REQ-021 Beat counter SHALL advance only on m_TVALID && m_TREADY; m_TDATA/m_TKEEP/m_TLAST/m_TID SHALL hold stable while m_TVALID && !m_TREADY.
REQ-022 m_TLAST SHALL be high exactly on beat N-1.
REQ-023 Handshake on beat N-1 SHALL return FSM to IDLE; m_TVALID low next cycle unless REQ-024 applies.
REQ-024 Din_valid coincident with the final-beat handshake SHALL be accepted (back-to-back), SEND re-entered with counter 0, m_TVALID staying high.
REQ-025 Din_valid in SEND other than REQ-024 SHALL be ignored, held digest untouched, Overrun pulsed for one cycle.
REQ-026 Busy SHALL equal (state == SEND).
REQ-027 Outputs SHALL not depend combinationally on m_TREADY.

Reset
REQ-028 ARESET SHALL asynchronously force IDLE, counter 0, m_TVALID=0, m_TLAST=0, m_TDATA=0, m_TKEEP=0, m_TID=0, Busy=0, Overrun=0.
REQ-029 Reset mid-digest SHALL abandon it; first post-reset Din_valid SHALL start a fresh digest at beat 0.
REQ-030 Holding register SHALL need no reset (not observable while IDLE).

Structure
REQ-031 Shared package sha3_pkg SHALL hold the TID encoding enum, digest-length constants (224/256/384/512), and function beats(len, width).
REQ-032 Block SHALL be one module, no sub-modules; beat select is a counter-indexed mux over the 512-bit holding register.

Verification
REQ-033 Din lane0=64'h66D71EBFF8C6FFA7 (SHA3-256("") bytes 0..7), TID=1, DATA_WIDTH=16, TREADY=1 -> 16 beats, beat0 m_TDATA=16'hFFA7, beat3=16'h66D7, m_TLAST on beat 15 only.
REQ-034 TID=0, DATA_WIDTH=64 -> 4 beats, beat 3 m_TKEEP=8'h0F, upper 32 bits zero, m_TLAST=1.
REQ-035 TID=3, TREADY toggling 1010... -> 32 beats, no duplicates/skips, outputs stable on stalled cycles.
REQ-036 Second Din_valid at beat 5 of SHA3-512 -> Overrun one cycle, original digest completes unchanged.
REQ-037 Din_valid on final-beat handshake -> next digest beat 0 following cycle, m_TVALID never drops.
REQ-038 ARESET at beat 7 of SHA3-384 -> all outputs zero same cycle; new Din_valid -> beat 0 of new digest.
